gmii_rx_speed_ctrl: RTL and testbench

GMII_RX_SPEED_CTRL -- requirements
Module: gmii_rx_speed_ctrl

---
 rtl/gmii_rx_speed_ctrl_pkg.sv | 44 ++++
 rtl/gmii_rx_speed_ctrl.sv | 174 +++++++++++++++++
 tb/tb_gmii_rx_speed_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/gmii_rx_speed_ctrl_pkg.sv
// Shared Ethernet definitions for the GMII receive speed controller.
// - speed_t       : line-rate encoding used on speed_req / speed_active
// - state_t       : controller states
// - DIV_LAST_*    : last count of the 7-bit clock-enable divider per speed
// - normalize_speed / div_last : helpers used by the controller
package gmii_rx_speed_ctrl_pkg;

  typedef enum logic [1:0] {
    SPEED_10M  = 2'b00,
    SPEED_100M = 2'b01,
    SPEED_1G   = 2'b10
  } speed_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_DRAIN = 2'b01,
    ST_HOLD  = 2'b10
  } state_t;

  localparam int DIV_W = 7;

  // Divide ratios of a 125 MHz byte-replicated stream: 1, 10 and 100.
  localparam logic [DIV_W-1:0] DIV_LAST_1G   = 7'd0;
  localparam logic [DIV_W-1:0] DIV_LAST_100M = 7'd9;
  localparam logic [DIV_W-1:0] DIV_LAST_10M  = 7'd99;

  // The unused encoding 2'b11 is folded onto 1G.
  function automatic speed_t normalize_speed(input logic [1:0] raw);
    case (raw)
      2'b00:   return SPEED_10M;
      2'b01:   return SPEED_100M;
      default: return SPEED_1G;
    endcase
  endfunction

  function automatic logic [DIV_W-1:0] div_last(input speed_t speed);
    case (speed)
      SPEED_10M:  return DIV_LAST_10M;
      SPEED_100M: return DIV_LAST_100M;
      default:    return DIV_LAST_1G;
    endcase
  endfunction

endpackage

// File: rtl/gmii_rx_speed_ctrl.sv
// GMII receive speed controller.
// Watches the requested speed / PHY interface type and, when they change,
// waits for an inter-frame gap on gmii_rx_dv (or a drain timeout), holds the
// receiver in reset while the new configuration is applied, then releases it.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   speed_req[1:0]  : requested speed (00=10M, 01=100M, 10/11=1G)
//   iface_mii       : 1 = native MII PHY clock, 0 = byte-replicated 125 MHz
//   gmii_rx_dv      : raw receive data valid, used to find frame boundaries
//   rx_clk_enable   : receiver clock enable
//   rx_mii_select   : receiver MII (nibble) mode select
//   rx_rst          : synchronous reset to the receiver
//   speed_active    : speed currently applied
//   switch_busy     : a switch is in progress (DRAIN or HOLD)
//   switch_done     : one-cycle pulse when the receiver is released
//   switch_forced   : one-cycle pulse when the drain gave up on an idle gap
module gmii_rx_speed_ctrl
  import gmii_rx_speed_ctrl_pkg::*;
#(
  parameter int IFG_CYCLES    = 12,
  parameter int HOLD_CYCLES   = 4,
  parameter int DRAIN_TIMEOUT = 16384
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] speed_req,
  input  logic       iface_mii,
  input  logic       gmii_rx_dv,
  output logic       rx_clk_enable,
  output logic       rx_mii_select,
  output logic       rx_rst,
  output logic [1:0] speed_active,
  output logic       switch_busy,
  output logic       switch_done,
  output logic       switch_forced
);

  localparam int IFG_W   = $clog2(IFG_CYCLES + 1);
  localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
  localparam int DRAIN_W = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [IFG_W-1:0]   IFG_LAST   = IFG_W'(IFG_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_TIMEOUT - 1);

  state_t             state, nxt_state;
  speed_t             speed_q, nxt_speed;
  logic               mii_q, nxt_mii;
  logic [IFG_W-1:0]   ifg_cnt, nxt_ifg;
  logic [HOLD_W-1:0]  hold_cnt, nxt_hold;
  logic [DRAIN_W-1:0] drain_cnt, nxt_drain;
  logic [DIV_W-1:0]   div_cnt, nxt_div;

  logic nxt_clk_enable, nxt_mii_select, nxt_rx_rst;
  logic nxt_busy, nxt_done, nxt_forced;

  speed_t           req_speed;
  logic             cfg_differs;
  logic [DIV_W-1:0] div_step;

  assign speed_active = speed_q;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path through
    // the case below can leave a value unassigned and infer a latch.
    nxt_state      = state;
    nxt_speed      = speed_q;
    nxt_mii        = mii_q;
    nxt_ifg        = ifg_cnt;
    nxt_hold       = hold_cnt;
    nxt_drain      = drain_cnt;
    nxt_div        = div_cnt;
    nxt_done       = 1'b0;
    nxt_forced     = 1'b0;
    nxt_clk_enable = 1'b0;
    nxt_mii_select = 1'b0;
    nxt_rx_rst     = 1'b1;
    nxt_busy       = 1'b1;

    req_speed   = normalize_speed(speed_req);
    cfg_differs = (req_speed != speed_q) || (iface_mii != mii_q);
    // The divider keeps running through DRAIN: the old frame is still being
    // received with the old configuration.
    div_step    = (div_cnt == div_last(speed_q)) ? '0 : div_cnt + DIV_W'(1);

    case (state)
      ST_RUN: begin
        nxt_div = div_step;
        if (cfg_differs) begin
          nxt_state = ST_DRAIN;
          nxt_ifg   = '0;
          nxt_drain = '0;
        end
      end

      ST_DRAIN: begin
        nxt_div = div_step;
        if (!cfg_differs) begin
          // Request withdrawn: nothing to apply, resume without a reset.
          nxt_state = ST_RUN;
        end else if (!gmii_rx_dv && ifg_cnt == IFG_LAST) begin
          nxt_state = ST_HOLD;
          nxt_hold  = '0;
        end else if (drain_cnt == DRAIN_LAST) begin
          nxt_state  = ST_HOLD;
          nxt_hold   = '0;
          nxt_forced = 1'b1;
        end else begin
          nxt_ifg   = gmii_rx_dv ? '0 : ifg_cnt + IFG_W'(1);
          nxt_drain = drain_cnt + DRAIN_W'(1);
        end
      end

      default: begin  // ST_HOLD
        // Sampled every hold cycle so a late change of mind still lands.
        nxt_speed = req_speed;
        nxt_mii   = iface_mii;
        if (hold_cnt == HOLD_LAST) begin
          nxt_state = ST_RUN;
          nxt_done  = 1'b1;
          nxt_div   = '0;
        end else begin
          nxt_hold = hold_cnt + HOLD_W'(1);
        end
      end
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    if (nxt_state != ST_HOLD) begin
      nxt_rx_rst     = 1'b0;
      nxt_busy       = (nxt_state != ST_RUN);
      nxt_mii_select = nxt_mii && (nxt_speed != SPEED_1G);
      // A native MII/GMII PHY supplies its own clock, so the receiver is
      // always enabled; the replicated stream is thinned by the divider.
      nxt_clk_enable = nxt_mii ? 1'b1 : (nxt_div == '0);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_HOLD;
      speed_q       <= SPEED_1G;
      mii_q         <= 1'b0;
      ifg_cnt       <= '0;
      hold_cnt      <= '0;
      drain_cnt     <= '0;
      div_cnt       <= '0;
      rx_rst        <= 1'b1;
      rx_clk_enable <= 1'b0;
      rx_mii_select <= 1'b0;
      switch_busy   <= 1'b1;
      switch_done   <= 1'b0;
      switch_forced <= 1'b0;
    end else begin
      state         <= nxt_state;
      speed_q       <= nxt_speed;
      mii_q         <= nxt_mii;
      ifg_cnt       <= nxt_ifg;
      hold_cnt      <= nxt_hold;
      drain_cnt     <= nxt_drain;
      div_cnt       <= nxt_div;
      rx_rst        <= nxt_rx_rst;
      rx_clk_enable <= nxt_clk_enable;
      rx_mii_select <= nxt_mii_select;
      switch_busy   <= nxt_busy;
      switch_done   <= nxt_done;
      switch_forced <= nxt_forced;
    end
  end

endmodule

// File: tb/tb_gmii_rx_speed_ctrl.sv
// Self-checking bench for gmii_rx_speed_ctrl (DRAIN_TIMEOUT shortened to 64).
// Each tick pushes the outputs expected after the next clock edge into a
// scoreboard; a monitor pops and compares them 1 ns after that edge.
module tb_gmii_rx_speed_ctrl;

  typedef struct packed {
    logic       rx_rst;
    logic       en;
    logic       sel;
    logic [1:0] spd;
    logic       busy;
    logic       done;
    logic       forced;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] speed_req;
  logic       iface_mii;
  logic       gmii_rx_dv;
  logic       rx_clk_enable;
  logic       rx_mii_select;
  logic       rx_rst;
  logic [1:0] speed_active;
  logic       switch_busy;
  logic       switch_done;
  logic       switch_forced;

  int    n_checks = 0;
  int    n_errors = 0;
  exp_t  sb_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  gmii_rx_speed_ctrl #(
    .IFG_CYCLES   (12),
    .HOLD_CYCLES  (4),
    .DRAIN_TIMEOUT(64)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .speed_req    (speed_req),
    .iface_mii    (iface_mii),
    .gmii_rx_dv   (gmii_rx_dv),
    .rx_clk_enable(rx_clk_enable),
    .rx_mii_select(rx_mii_select),
    .rx_rst       (rx_rst),
    .speed_active (speed_active),
    .switch_busy  (switch_busy),
    .switch_done  (switch_done),
    .switch_forced(switch_forced)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (rst,en,sel,spd[2],busy,done,forced)",
               tag, obs, exp);
    end
  endtask

  function automatic exp_t ex(input logic r, input logic en, input logic sel,
                              input logic [1:0] spd, input logic busy,
                              input logic done, input logic forced);
    exp_t e;
    e.rx_rst = r;
    e.en     = en;
    e.sel    = sel;
    e.spd    = spd;
    e.busy   = busy;
    e.done   = done;
    e.forced = forced;
    return e;
  endfunction

  // Expected outputs after the next edge, given the inputs now applied.
  task automatic tick(input string tag, input exp_t e);
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() != 0) begin
      exp_t  e;
      string t;
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      check(t, 32'({rx_rst, rx_clk_enable, rx_mii_select, speed_active,
                    switch_busy, switch_done, switch_forced}), 32'(e));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int k;
    rst        = 1'b1;
    speed_req  = 2'b10;
    iface_mii  = 1'b0;
    gmii_rx_dv = 1'b0;

    // Reset into 1G on the replicated stream.
    tick("rst0", ex(1, 0, 0, 2'b10, 1, 0, 0));
    tick("rst1", ex(1, 0, 0, 2'b10, 1, 0, 0));
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick("a_hold", ex(1, 0, 0, 2'b10, 1, 0, 0));
    tick("a_done", ex(0, 1, 0, 2'b10, 0, 1, 0));
    for (int i = 0; i < 10; i++) tick("a_run", ex(0, 1, 0, 2'b10, 0, 0, 0));

    // 11 means 1G: no switch when 1G is already applied.
    speed_req = 2'b11;
    for (int i = 0; i < 5; i++) tick("a_req11", ex(0, 1, 0, 2'b10, 0, 0, 0));

    // 1G -> 100M while a frame is in flight for 40 cycles.
    gmii_rx_dv = 1'b1;
    speed_req  = 2'b01;
    for (int i = 0; i < 40; i++) tick("b_drain_dv", ex(0, 1, 0, 2'b10, 1, 0, 0));
    gmii_rx_dv = 1'b0;
    for (int i = 0; i < 11; i++) tick("b_drain_idle", ex(0, 1, 0, 2'b10, 1, 0, 0));
    tick("b_hold0", ex(1, 0, 0, 2'b10, 1, 0, 0));
    for (int i = 0; i < 3; i++) tick("b_hold", ex(1, 0, 0, 2'b01, 1, 0, 0));
    tick("b_done", ex(0, 1, 0, 2'b01, 0, 1, 0));
    k = 1;
    for (int i = 0; i < 29; i++) begin
      tick("b_run_div10", ex(0, (k % 10) == 0, 0, 2'b01, 0, 0, 0));
      k++;
    end

    // Request 1G then withdraw it inside DRAIN: divider phase must carry on.
    speed_req = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick("c_drain", ex(0, (k % 10) == 0, 0, 2'b01, 1, 0, 0));
      k++;
    end
    speed_req = 2'b01;
    for (int i = 0; i < 17; i++) begin
      tick("c_revert_run", ex(0, (k % 10) == 0, 0, 2'b01, 0, 0, 0));
      k++;
    end

    // Native MII PHY at 10M.
    iface_mii = 1'b1;
    speed_req = 2'b00;
    for (int i = 0; i < 12; i++) begin
      tick("d_drain", ex(0, (k % 10) == 0, 0, 2'b01, 1, 0, 0));
      k++;
    end
    tick("d_hold0", ex(1, 0, 0, 2'b01, 1, 0, 0));
    for (int i = 0; i < 3; i++) tick("d_hold", ex(1, 0, 0, 2'b00, 1, 0, 0));
    tick("d_done", ex(0, 1, 1, 2'b00, 0, 1, 0));
    for (int i = 0; i < 10; i++) tick("d_run_mii", ex(0, 1, 1, 2'b00, 0, 0, 0));

    // dv never drops: forced switch after 64 DRAIN cycles.
    iface_mii  = 1'b0;
    speed_req  = 2'b10;
    gmii_rx_dv = 1'b1;
    for (int i = 0; i < 64; i++) tick("e_drain_busy", ex(0, 1, 1, 2'b00, 1, 0, 0));
    tick("e_forced", ex(1, 0, 0, 2'b00, 1, 0, 1));
    for (int i = 0; i < 3; i++) tick("e_hold", ex(1, 0, 0, 2'b10, 1, 0, 0));
    tick("e_done", ex(0, 1, 0, 2'b10, 0, 1, 0));
    for (int i = 0; i < 5; i++) tick("e_run", ex(0, 1, 0, 2'b10, 0, 0, 0));

    // rst during the second HOLD cycle restarts the hold.
    gmii_rx_dv = 1'b0;
    speed_req  = 2'b01;
    for (int i = 0; i < 12; i++) tick("f_drain", ex(0, 1, 0, 2'b10, 1, 0, 0));
    tick("f_hold0", ex(1, 0, 0, 2'b10, 1, 0, 0));
    tick("f_hold1", ex(1, 0, 0, 2'b01, 1, 0, 0));
    rst = 1'b1;
    tick("f_rst", ex(1, 0, 0, 2'b10, 1, 0, 0));
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick("f_hold_again", ex(1, 0, 0, 2'b01, 1, 0, 0));
    tick("f_done", ex(0, 1, 0, 2'b01, 0, 1, 0));
    k = 1;
    for (int i = 0; i < 14; i++) begin
      tick("f_run_div10", ex(0, (k % 10) == 0, 0, 2'b01, 0, 0, 0));
      k++;
    end

    // Request 11 (=1G), then change to 10M mid-HOLD: last value wins, no restart.
    speed_req = 2'b11;
    for (int i = 0; i < 12; i++) begin
      tick("g_drain", ex(0, (k % 10) == 0, 0, 2'b01, 1, 0, 0));
      k++;
    end
    tick("g_hold0", ex(1, 0, 0, 2'b01, 1, 0, 0));
    tick("g_hold1", ex(1, 0, 0, 2'b10, 1, 0, 0));
    speed_req = 2'b00;
    tick("g_hold2", ex(1, 0, 0, 2'b00, 1, 0, 0));
    tick("g_hold3", ex(1, 0, 0, 2'b00, 1, 0, 0));
    tick("g_done", ex(0, 1, 0, 2'b00, 0, 1, 0));
    k = 1;
    for (int i = 0; i < 104; i++) begin
      tick("g_run_div100", ex(0, (k % 100) == 0, 0, 2'b00, 0, 0, 0));
      k++;
    end

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
